// File: rtl/uart_tx_gen_if.sv
// Word handshake between the register file and the UART transmitter.
interface uart_tx_gen_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] Data;
  logic                  Data_valid;
  logic                  Data_ready;

  modport master (output Data, output Data_valid, input  Data_ready);
  modport slave  (input  Data, input  Data_valid, output Data_ready);
endinterface

// File: rtl/uart_tx_gen.sv
// UART transmitter with baud prescaler, optional parity, 1/2 stop bits and a
// one-entry holding register so frames can run back-to-back.
module uart_tx_gen #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  Parity_EN,
  input  logic                  Parity_type,
  input  logic                  Stop2,
  uart_tx_gen_if.slave          bus,
  output logic                  Tx_out,
  output logic                  Busy,
  output logic                  Frame_done
);

  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]            state, state_n;
  logic [PRESCALE_W-1:0] baud_cnt, baud_n, pres_q, pres_n;
  logic [BIT_W-1:0]      bit_cnt, bit_n;
  logic                  stop_cnt, stop_n;
  logic [DATA_WIDTH-1:0] shifter, shift_n, hold_data, hdata_n;
  logic                  par_bit, par_n, par_en_q, pen_n, stop2_q, s2_n;
  logic                  hold_pen, hpen_n, hold_ptype, hptype_n, hold_s2, hs2_n;
  logic                  hold_empty, hempty_n;
  logic                  tx_q, tx_n, busy_q, busy_n, done_q, done_n;
  logic                  bit_end, last_stop;

  assign bit_end   = (baud_cnt == pres_q);
  assign last_stop = (state == ST_STOP) && bit_end && (stop_cnt == stop2_q);

  assign bus.Data_ready = hold_empty;
  assign Tx_out         = tx_q;
  assign Busy           = busy_q;
  assign Frame_done     = done_q;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_n  = state;
    baud_n   = baud_cnt;
    bit_n    = bit_cnt;
    stop_n   = stop_cnt;
    shift_n  = shifter;
    par_n    = par_bit;
    pen_n    = par_en_q;
    s2_n     = stop2_q;
    pres_n   = pres_q;
    hdata_n  = hold_data;
    hpen_n   = hold_pen;
    hptype_n = hold_ptype;
    hs2_n    = hold_s2;
    hempty_n = hold_empty;
    tx_n     = 1'b1;
    busy_n   = 1'b0;
    done_n   = 1'b0;

    unique case (state)
      ST_START: begin
        if (bit_end) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = ST_DATA;
        end else begin
          baud_n = baud_cnt + PRESCALE_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_n  = '0;
          shift_n = shifter >> 1;
          if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
            stop_n  = 1'b0;
            state_n = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_n = bit_cnt + BIT_W'(1);
          end
        end else begin
          baud_n = baud_cnt + PRESCALE_W'(1);
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          baud_n  = '0;
          stop_n  = 1'b0;
          state_n = ST_STOP;
        end else begin
          baud_n = baud_cnt + PRESCALE_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (stop_cnt == stop2_q) state_n = ST_IDLE;
          else                     stop_n  = 1'b1;
        end else begin
          baud_n = baud_cnt + PRESCALE_W'(1);
        end
      end
      default: ;
    endcase

    // Holding register hands over to the shifter; Prescale is latched here.
    if (!hold_empty && ((state == ST_IDLE) || last_stop)) begin
      state_n  = ST_START;
      baud_n   = '0;
      bit_n    = '0;
      stop_n   = 1'b0;
      shift_n  = hold_data;
      par_n    = hold_ptype ? ~^hold_data : ^hold_data;
      pen_n    = hold_pen;
      s2_n     = hold_s2;
      pres_n   = Prescale;
      hempty_n = 1'b1;
    end

    if (hold_empty && bus.Data_valid) begin
      hdata_n  = bus.Data;
      hpen_n   = Parity_EN;
      hptype_n = Parity_type;
      hs2_n    = Stop2;
      hempty_n = 1'b0;
    end

    unique case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shift_n[0];
      ST_PARITY: tx_n = par_n;
      default:   tx_n = 1'b1;
    endcase
    busy_n = (state_n != ST_IDLE);
    done_n = (state_n == ST_STOP) && (baud_n == pres_n) && (stop_n == s2_n);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shifter    <= '0;
      par_bit    <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      pres_q     <= '0;
      hold_data  <= '0;
      hold_pen   <= 1'b0;
      hold_ptype <= 1'b0;
      hold_s2    <= 1'b0;
      hold_empty <= 1'b1;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_n;
      bit_cnt    <= bit_n;
      stop_cnt   <= stop_n;
      shifter    <= shift_n;
      par_bit    <= par_n;
      par_en_q   <= pen_n;
      stop2_q    <= s2_n;
      pres_q     <= pres_n;
      hold_data  <= hdata_n;
      hold_pen   <= hpen_n;
      hold_ptype <= hptype_n;
      hold_s2    <= hs2_n;
      hold_empty <= hempty_n;
      tx_q       <= tx_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_gen.sv
// Bench for uart_tx_gen: directed frames plus random traffic against a
// frame-level model that expands each accepted word into its line waveform.
module tb_uart_tx_gen;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [7:0] Prescale;
  logic       Parity_EN, Parity_type, Stop2;
  logic       Tx_out, Busy, Frame_done;

  uart_tx_gen_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_gen #(.DATA_WIDTH(8), .PRESCALE_W(8)) dut (
    .CLK(CLK), .Reset(Reset), .Prescale(Prescale), .Parity_EN(Parity_EN),
    .Parity_type(Parity_type), .Stop2(Stop2), .bus(bus),
    .Tx_out(Tx_out), .Busy(Busy), .Frame_done(Frame_done)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: queue of per-cycle line levels for the frame in flight, plus the
  // single word waiting to be sent.
  typedef struct { logic tx; logic done; } cyc_t;
  typedef struct { logic [7:0] d; logic pe; logic pt; logic s2; } word_t;
  cyc_t  line_q[$];
  word_t pend_q[$];
  logic  exp_tx, exp_busy, exp_done, exp_ready;
  bit    started = 1'b0;

  function automatic void build(input word_t w, input logic [7:0] pres);
    logic bits[$];
    cyc_t c;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(w.d[i]);
    if (w.pe) bits.push_back(w.pt ? ~^w.d : ^w.d);
    bits.push_back(1'b1);
    if (w.s2) bits.push_back(1'b1);
    for (int j = 0; j < bits.size(); j++)
      for (int r = 0; r <= int'(pres); r++) begin
        c.tx   = bits[j];
        c.done = (j == bits.size() - 1) && (r == int'(pres));
        line_q.push_back(c);
      end
  endfunction

  always @(posedge CLK) begin
    bit    acc;
    word_t w;
    if (Reset) begin
      line_q.delete();
      pend_q.delete();
    end else begin
      acc = bus.Data_valid && (pend_q.size() == 0);
      if (line_q.size() != 0) void'(line_q.pop_front());
      if (line_q.size() == 0 && pend_q.size() != 0) begin
        w = pend_q.pop_front();
        build(w, Prescale);
      end
      if (acc) begin
        w.d = bus.Data; w.pe = Parity_EN; w.pt = Parity_type; w.s2 = Stop2;
        pend_q.push_back(w);
      end
    end
    if (line_q.size() != 0) begin
      exp_tx = line_q[0].tx; exp_busy = 1'b1; exp_done = line_q[0].done;
    end else begin
      exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
    end
    exp_ready = (pend_q.size() == 0);
    started   = 1'b1;
  end

  // Cycle-by-cycle comparison plus busy-run and pulse bookkeeping.
  int busy_run = 0, last_len = 0, done_cnt = 0;
  always @(negedge CLK) begin
    if (started) begin
      check("tx_out", 32'(Tx_out), 32'(exp_tx));
      check("busy", 32'(Busy), 32'(exp_busy));
      check("frame_done", 32'(Frame_done), 32'(exp_done));
      check("data_ready", 32'(bus.Data_ready), 32'(exp_ready));
    end
    if (Frame_done) done_cnt++;
    if (Busy) busy_run++;
    else if (busy_run != 0) begin last_len = busy_run; busy_run = 0; end
  end

  // Offer a word (call at a negedge); returns at the negedge after accept.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic s2, input bit keep);
    bit ok = 1'b0;
    bus.Data = d; Parity_EN = pe; Parity_type = pt; Stop2 = s2;
    bus.Data_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (bus.Data_ready) begin ok = 1'b1; @(negedge CLK); break; end
      @(negedge CLK);
    end
    check("send_accept", 32'(ok), 32'd1);
    if (!keep) bus.Data_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int exp_len, input int exp_frames, input int d0);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      if (!Busy && line_q.size() == 0 && pend_q.size() == 0) begin ok = 1'b1; break; end
    end
    #1;
    check({tag, "_idle"}, 32'(ok), 32'd1);
    if (exp_len >= 0) check({tag, "_len"}, 32'(last_len), 32'(exp_len));
    check({tag, "_pulses"}, 32'(done_cnt - d0), 32'(exp_frames));
    @(negedge CLK);
  endtask

  task automatic pulse_reset();
    Reset = 1'b1; bus.Data_valid = 1'b1; bus.Data = 8'h99;
    @(negedge CLK);
    Reset = 1'b0; bus.Data_valid = 1'b0;
  endtask

  initial begin
    int d0;
    Reset = 1'b1; Prescale = '0; Parity_EN = 0; Parity_type = 0; Stop2 = 0;
    bus.Data = '0; bus.Data_valid = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_tx", 32'(Tx_out), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_ready", 32'(bus.Data_ready), 32'd1);
    Reset = 1'b0;
    @(negedge CLK);

    d0 = done_cnt; send(8'hA5, 0, 0, 0, 0); wait_idle("basic", 10, 1, d0);
    d0 = done_cnt; send(8'h07, 1, 0, 0, 0); wait_idle("par_even", 11, 1, d0);
    d0 = done_cnt; send(8'h07, 1, 1, 0, 0); wait_idle("par_odd", 11, 1, d0);
    Prescale = 8'd3;
    d0 = done_cnt; send(8'h00, 0, 0, 1, 0); wait_idle("pres_stop2", 44, 1, d0);

    Prescale = 8'd1;
    d0 = done_cnt;
    send(8'h55, 0, 0, 0, 1);
    send(8'hAA, 0, 0, 0, 0);
    wait_idle("b2b", 40, 2, d0);

    // Reset lands during data bit 3; a clean frame must follow.
    Prescale = 8'd0;
    d0 = done_cnt;
    send(8'hF0, 0, 0, 0, 0);
    repeat (4) @(negedge CLK);
    pulse_reset();
    #1; check("rst_mid_pulses", 32'(done_cnt - d0), 32'd0);
    @(negedge CLK);
    d0 = done_cnt; send(8'h3C, 0, 0, 0, 0); wait_idle("after_rst", 10, 1, d0);

    // Config changes mid-frame only affect the next frame.
    Prescale = 8'd1;
    d0 = done_cnt;
    send(8'h0F, 0, 0, 0, 0);
    repeat (2) @(negedge CLK);
    Prescale = 8'd3; Stop2 = 1'b1; Parity_EN = 1'b1;
    wait_idle("cfg1", 20, 1, d0);
    d0 = done_cnt; send(8'h0F, 0, 0, 1, 0); wait_idle("cfg2", 44, 1, d0);

    // Random traffic with random gaps, Prescale churn and occasional resets.
    for (int f = 0; f < 40; f++) begin
      int gap = int'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) Prescale = 8'($urandom_range(0, 3));
      if (gap != 0) begin
        bus.Data_valid = 1'b0;
        repeat (gap) @(negedge CLK);
      end
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) Prescale = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) begin
        bus.Data_valid = 1'b0;
        repeat ($urandom_range(1, 20)) @(negedge CLK);
        pulse_reset();
      end
    end
    bus.Data_valid = 1'b0;
    d0 = done_cnt;
    wait_idle("rand_drain", -1, (line_q.size() != 0 ? 1 : 0) + pend_q.size(), d0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_gen.md
# uart_tx_gen

Parametrised UART transmitter for the low-power communication system. It replaces the fixed one-bit-per-clock transmitter with three additions:
- a programmable baud prescaler,
- optional 1 or 2 stop bits,
- a one-entry holding register behind a valid/ready handshake, so frames can be sent back-to-back with no idle gap.

It sits between the system controller/register file and the serial line.

## Interface
- DATA_WIDTH, 8, data bits per frame (5..16)
- PRESCALE_W, 8, width of Prescale input

- CLK  input  1  system clock, all logic on rising edge
- Reset  input  1  synchronous, active-high reset
- Prescale  input  PRESCALE_W  bit period = Prescale+1 CLK cycles
- Parity_EN  input  1  1 = append parity bit
- Parity_type  input  1  1 = odd (bit = ~^data), 0 = even (bit = ^data)
- Stop2  input  1  1 = two stop bits, 0 = one
- Data  input  DATA_WIDTH  word to send
- Data_valid  input  1  word offered
- Data_ready  output  1  holding register empty; transfer when Data_valid && Data_ready
- Tx_out  output  1  serial line, registered, idle high
- Busy  output  1  high while any frame bit is on the line
- Frame_done  output  1  one-cycle pulse on the final stop-bit cycle

## Operation
- Reset values: Tx_out=1, Busy=0, Data_ready=1, Frame_done=0, FSM=IDLE, holding empty, counters 0.
- Handshake and holding register:
  - Data_ready = ~hold_valid.
  - On accept, the holding register captures Data, Parity_EN, Parity_type and Stop2.
  - Parity is computed from the captured word.
- Transfer and frame start:
  - Holding moves to the shifter when FSM is IDLE, or on the last cycle of the final stop bit.
  - hold_valid clears on transfer.
  - Prescale is sampled at transfer and used for the whole frame.
- FSM: IDLE -> START -> DATA -> [PARITY if Parity_EN] -> STOP -> (START if holding full, else IDLE).
- Bit timing:
  - A baud counter counts 0..Prescale_captured; a bit ends when it reaches the captured value.
  - DATA shifts out LSB first, with a bit counter 0..DATA_WIDTH-1.
  - STOP lasts 1 or 2 bit periods per the captured Stop2.
- Line levels: START drives 0, DATA drives shifter LSB, PARITY drives the captured parity bit, STOP and IDLE drive 1.
- Output registering:
  - Tx_out and Busy are registered from the next-state decode.
  - Frame_done is registered and coincides with the last stop-bit cycle on Tx_out.
- Reset mid-frame: line returns to 1 at the next edge; holding and shifter are discarded; no Frame_done is generated.
- Frame length: (1 + DATA_WIDTH + Parity_EN + 1 + Stop2) × (Prescale+1) cycles.
- Prescale=0 gives one bit per CLK.

## Timing
- Accept at edge k with FSM IDLE:
  - hold_valid=1 after k, so Data_ready=0 for one cycle.
  - Transfer at edge k+1: Tx_out=0 and Busy=1 from edge k+1.
  - Data_ready=1 again after k+1.
- Back-to-back:
  - With holding full at the end of the final stop bit, the next START bit appears on the very next cycle.
  - Busy stays high continuously.
  - Frame_done pulses once per frame.
- Stalling:
  - A word accepted while a frame is in flight waits in holding.
  - Data_ready stays 0 until that word transfers.
  - Data_valid held high while Data_ready=0 causes no capture and no duplication.
- Config changes:
  - Parity_EN, Parity_type and Stop2 matter only at accept.
  - Prescale matters only at transfer.
  - Mid-frame changes have no effect on the current frame.
- Idle: after the final stop bit with holding empty, FSM goes to IDLE; Busy=0 and Tx_out=1 from the next edge.
- Reset dominates a simultaneous Data_valid, which is not accepted.

## Test plan
- Basic frame:
  - Stimulus: Prescale=0, no parity, Stop2=0, send 0xA5.
  - Response: Tx_out = 0,1,0,1,0,0,1,0,1,1, one cycle each; Busy high exactly 10 cycles; Frame_done on cycle 10.
- Parity:
  - Stimulus: 0x07 with Parity_EN=1.
  - Response: Parity_type=0 gives parity bit 1; Parity_type=1 gives parity bit 0; frame is 11 cycles.
- Prescale and stop bits:
  - Stimulus: Prescale=3, Stop2=1, send 0x00.
  - Response: every bit 4 cycles; frame 44 cycles; the final 8 cycles high; Frame_done on cycle 44 only.
- Back-to-back:
  - Stimulus: Data_valid held high with 0x55 then 0xAA, Prescale=1.
  - Response: second START immediately follows first stop; Busy never drops between frames; exactly 2 Frame_done pulses; Data_ready low while holding full.
- Reset mid-frame:
  - Stimulus: Reset for one cycle during data bit 3.
  - Response: next edge gives Tx_out=1, Busy=0, Data_ready=1, no Frame_done; a following 0x3C transmits as a clean full frame.
- Config change mid-frame:
  - Stimulus: toggle Prescale and Stop2 during a frame.
  - Response: current frame keeps its original bit period and stop count; the next frame uses the new values.
